// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, control-word and FSM definitions for the decode stage
package ctrl_pkg;

    localparam logic [5:0] OP_HALT = 6'b000000;
    localparam logic [5:0] OP_LOAD = 6'b000010;
    localparam logic [5:0] OP_BEQZ = 6'b000011;
    localparam logic [5:0] OP_CL   = 6'b000110;
    localparam logic [5:0] OP_OFC  = 6'b001000;
    localparam logic [5:0] OP_ADDC = 6'b001011;
    localparam logic [5:0] OP_XOR  = 6'b001100;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_PASS = 4'b1011;
    localparam logic [3:0] ALU_ADD  = 4'b1100;
    localparam logic [3:0] ALU_ADDC = 4'b1110;
    localparam logic [3:0] ALU_XOR  = 4'b1111;

    localparam logic [1:0] WD_IMM  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_ALU  = 2'b10;
    localparam logic [1:0] WD_NONE = 2'b11;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_R1   = 2'b10;
    localparam logic [1:0] RW_RS   = 2'b11;

    typedef struct packed {
        logic       branch;
        logic [1:0] wd_src;
        logic [1:0] reg_write;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       ofc;
        logic       valid;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_WORD = '{
        branch:    1'b0,
        wd_src:    WD_NONE,
        reg_write: RW_NONE,
        alu_op:    ALU_NOP,
        mem_read:  1'b0,
        mem_write: 1'b0,
        ofc:       1'b0,
        valid:     1'b0
    };

    typedef enum logic [2:0] {RUN, MEM_WAIT, RESOLVE, FLUSH, HALTED} state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode field to control word plus illegal-opcode flag
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_word_t word,
    output logic       illegal
);
    logic sys_op;
    assign sys_op = (op == OP_HALT) || (op == OP_OFC);
    always_comb begin
        word = NOP_WORD;
        illegal = 1'b0;
        casez (op)
            6'b000???, 6'b0010??, 6'b001100: begin
                word.valid = 1'b1;
                word.ofc = sys_op;
                word.wd_src = sys_op ? WD_NONE : (op == OP_LOAD) ? WD_MEM : WD_ALU;
                word.reg_write = sys_op ? RW_NONE : (op == OP_CL || op == OP_ADDC) ? RW_RS : RW_R1;
                word.alu_op = (op == OP_ADDC) ? ALU_ADDC : (op == OP_XOR) ? ALU_XOR : op[3:0];
                word.mem_read = (op == OP_LOAD);
            end
            6'b010???: begin
                word.valid = 1'b1;
                word.wd_src = WD_ALU;
                word.reg_write = RW_RS;
                word.alu_op = ALU_ADD;
            end
            6'b011???: begin
                word.valid = 1'b1;
                word.alu_op = ALU_PASS;
                word.mem_write = 1'b1;
            end
            6'b1?????: begin
                word.valid = 1'b1;
                word.wd_src = WD_IMM;
                word.reg_write = RW_R1;
                word.alu_op = ALU_PASS;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered decode stage with load stalls, branch flush, sticky halt and illegal-op flag
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW         = 9,
    parameter int MEM_LAT    = 1,
    parameter int BR_BUBBLES = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] Instruction,
    input  logic          InstrValid,
    input  logic          Zero,
    input  logic          Start,
    output logic          BRANCH,
    output logic [1:0]    WD_SRC,
    output logic [1:0]    REG_WRITE,
    output logic [3:0]    ALU_OP,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic          OFC,
    output logic          HALT,
    output logic          Stall,
    output logic          CtrlValid,
    output logic          IllegalOp
);
    localparam logic [2:0] MEM_CNT = 3'(MEM_LAT);
    localparam logic [2:0] BR_CNT  = 3'(BR_BUBBLES);

    state_t     state;
    logic [2:0] cnt;
    ctrl_word_t cw;
    ctrl_word_t dec;
    logic       ill;
    logic [5:0] op;
    logic       unused_low;

    assign op = Instruction[IW-1:IW-6];
    assign unused_low = ^Instruction[IW-7:0];

    ctrl_decode u_decode (
        .op      (op),
        .word    (dec),
        .illegal (ill)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            cnt <= '0;
            cw <= NOP_WORD;
            Stall <= 1'b0;
            HALT <= 1'b0;
            IllegalOp <= 1'b0;
        end else begin
            cw <= NOP_WORD;
            Stall <= 1'b0;
            HALT <= 1'b0;
            IllegalOp <= 1'b0;
            case (state)
                RUN: if (InstrValid) begin
                    cw <= dec;
                    IllegalOp <= ill;
                    if (op == OP_LOAD && MEM_LAT > 0) begin
                        state <= MEM_WAIT;
                        cnt <= MEM_CNT;
                        Stall <= 1'b1;
                    end else if (op == OP_BEQZ) begin
                        state <= RESOLVE;
                        Stall <= 1'b1;
                    end else if (op == OP_HALT) begin
                        state <= HALTED;
                        Stall <= 1'b1;
                        HALT <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) state <= RUN;
                    else Stall <= 1'b1;
                end
                RESOLVE: begin
                    cw.branch <= Zero;
                    cnt <= BR_CNT;
                    state <= (Zero && BR_BUBBLES > 0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) state <= RUN;
                end
                HALTED: if (!Start) begin
                    Stall <= 1'b1;
                    HALT <= 1'b1;
                end else state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign BRANCH    = cw.branch;
    assign WD_SRC    = cw.wd_src;
    assign REG_WRITE = cw.reg_write;
    assign ALU_OP    = cw.alu_op;
    assign MEM_READ  = cw.mem_read;
    assign MEM_WRITE = cw.mem_write;
    assign OFC       = cw.ofc;
    assign CtrlValid = cw.valid;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: vector table, hand sequences and randomized cycle-schedule model for ctrl_seq
module tb_ctrl_seq;
    localparam int MEM_LAT = 2;
    localparam int BR_BUBBLES = 1;

    logic       Clk, Reset, InstrValid, Zero, Start;
    logic [8:0] Instruction;
    logic       BRANCH, MEM_READ, MEM_WRITE, OFC, HALT, Stall, CtrlValid, IllegalOp;
    logic [1:0] WD_SRC, REG_WRITE;
    logic [3:0] ALU_OP;
    logic [15:0] got;

    int n_chk = 0;
    int n_fail = 0;

    ctrl_seq #(.IW(9), .MEM_LAT(MEM_LAT), .BR_BUBBLES(BR_BUBBLES)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
        .Zero(Zero), .Start(Start), .BRANCH(BRANCH), .WD_SRC(WD_SRC), .REG_WRITE(REG_WRITE),
        .ALU_OP(ALU_OP), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .OFC(OFC), .HALT(HALT),
        .Stall(Stall), .CtrlValid(CtrlValid), .IllegalOp(IllegalOp)
    );

    assign got = {BRANCH, WD_SRC, REG_WRITE, ALU_OP, MEM_READ, MEM_WRITE, OFC, HALT, Stall, CtrlValid, IllegalOp};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] pk(logic br, logic [1:0] wd, logic [1:0] rw, logic [3:0] alu,
                                       logic mr, logic mw, logic of, logic hl, logic st, logic cv, logic il);
        return {br, wd, rw, alu, mr, mw, of, hl, st, cv, il};
    endfunction

    task automatic check(input string nm, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got br|wd|rw|alu|mr|mw|ofc|halt|stall|cv|ill=%b required %b", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic [8:0] ins, input logic v, input logic z, input logic s);
        Instruction = ins;
        InstrValid = v;
        Zero = z;
        Start = s;
        @(posedge Clk);
        #1;
    endtask

    // reference model: each accepted instruction schedules the output cycles it owns
    localparam int K_HOLD = 0, K_BUB = 1, K_RES = 2;
    int q[$];
    bit halted = 1'b0;

    task automatic ref_word(input int f, output logic [1:0] wd, output logic [1:0] rw, output logic [3:0] alu,
                            output logic mr, output logic mw, output logic of, output logic cv, output logic il);
        wd = 2'b11; rw = 2'b00; alu = 4'd0; mr = 0; mw = 0; of = 0; cv = 0; il = 0;
        if (f >= 32) begin wd = 2'b00; rw = 2'b10; alu = 4'd11; cv = 1; end
        else if (f >= 24) begin alu = 4'd11; mw = 1; cv = 1; end
        else if (f >= 16) begin wd = 2'b10; rw = 2'b11; alu = 4'd12; cv = 1; end
        else if (f >= 13) il = 1;
        else if (f == 0 || f == 8) begin of = 1; cv = 1; alu = 4'(f); end
        else begin
            cv = 1;
            wd = (f == 2) ? 2'b01 : 2'b10;
            rw = (f == 6 || f == 11) ? 2'b11 : 2'b10;
            alu = (f == 11) ? 4'd14 : (f == 12) ? 4'd15 : 4'(f);
            mr = (f == 2);
        end
    endtask

    task automatic model_step(input logic [8:0] ins, input logic v, input logic z, input logic s,
                              output logic [15:0] e);
        logic br, mr, mw, of, hl, st, cv, il;
        logic [1:0] wd, rw;
        logic [3:0] alu;
        int f, k;
        f = int'(ins[8:3]);
        br = 0; wd = 2'b11; rw = 2'b00; alu = 4'd0; mr = 0; mw = 0; of = 0; hl = 0; st = 0; cv = 0; il = 0;
        if (halted) begin
            if (s) halted = 1'b0;
            else begin hl = 1; st = 1; end
        end else if (q.size() > 0) begin
            k = q.pop_front();
            if (k == K_HOLD) st = 1;
            if (k == K_RES) begin
                br = z;
                if (z) repeat (BR_BUBBLES) q.push_back(K_BUB);
            end
        end else if (v) begin
            ref_word(f, wd, rw, alu, mr, mw, of, cv, il);
            if (f == 2 && MEM_LAT > 0) begin
                st = 1;
                repeat (MEM_LAT - 1) q.push_back(K_HOLD);
                q.push_back(K_BUB);
            end
            if (f == 3) begin st = 1; q.push_back(K_RES); end
            if (f == 0) begin st = 1; hl = 1; halted = 1'b1; end
        end
        e = pk(br, wd, rw, alu, mr, mw, of, hl, st, cv, il);
    endtask

    typedef struct {
        logic [8:0]  instr;
        logic        valid;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] nop_e, set_e;

    initial begin
        nop_e = pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        set_e = pk(0, 2'b00, 2'b10, 4'b1011, 0, 0, 0, 0, 0, 1, 0);
        vecs.push_back('{9'b1_0000_0101, 1'b1, set_e, "set"});
        vecs.push_back('{9'b010_000_011, 1'b1, pk(0, 2'b10, 2'b11, 4'b1100, 0, 0, 0, 0, 0, 1, 0), "add"});
        vecs.push_back('{9'b011_000_010, 1'b1, pk(0, 2'b11, 2'b00, 4'b1011, 0, 1, 0, 0, 0, 1, 0), "store"});
        vecs.push_back('{9'b000001_000, 1'b1, pk(0, 2'b10, 2'b10, 4'b0001, 0, 0, 0, 0, 0, 1, 0), "slt"});
        vecs.push_back('{9'b000100_011, 1'b1, pk(0, 2'b10, 2'b10, 4'b0100, 0, 0, 0, 0, 0, 1, 0), "sl"});
        vecs.push_back('{9'b000110_000, 1'b1, pk(0, 2'b10, 2'b11, 4'b0110, 0, 0, 0, 0, 0, 1, 0), "cl"});
        vecs.push_back('{9'b000111_000, 1'b1, pk(0, 2'b10, 2'b10, 4'b0111, 0, 0, 0, 0, 0, 1, 0), "sub"});
        vecs.push_back('{9'b001000_000, 1'b1, pk(0, 2'b11, 2'b00, 4'b1000, 0, 0, 1, 0, 0, 1, 0), "ofc"});
        vecs.push_back('{9'b001010_111, 1'b1, pk(0, 2'b10, 2'b10, 4'b1010, 0, 0, 0, 0, 0, 1, 0), "sgte"});
        vecs.push_back('{9'b001011_000, 1'b1, pk(0, 2'b10, 2'b11, 4'b1110, 0, 0, 0, 0, 0, 1, 0), "addc"});
        vecs.push_back('{9'b001100_000, 1'b1, pk(0, 2'b10, 2'b10, 4'b1111, 0, 0, 0, 0, 0, 1, 0), "xor"});
        vecs.push_back('{9'b001101_000, 1'b1, pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 1), "illegal_0d"});
        vecs.push_back('{9'b001111_101, 1'b1, pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 1), "illegal_0f"});
        vecs.push_back('{9'b001101_000, 1'b0, nop_e, "illegal_not_valid"});
        vecs.push_back('{9'b1_1111_1111, 1'b0, nop_e, "not_valid"});
        vecs.push_back('{9'b1_1111_1111, 1'b1, set_e, "set_ones"});

        Reset = 1'b0; Instruction = '0; InstrValid = 1'b0; Zero = 1'b0; Start = 1'b0;
        #12;
        check("reset_state", nop_e);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].instr, vecs[i].valid, 1'b0, 1'b0);
            check(vecs[i].name, vecs[i].exp);
        end

        cyc(9'b000010_000, 1'b1, 1'b0, 1'b0);
        check("load_issue", pk(0, 2'b01, 2'b10, 4'b0010, 1, 0, 0, 0, 1, 1, 0));
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("load_wait1", pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 0, 0, 1, 0, 0));
        cyc(9'b1_0000_0101, 1'b0, 1'b0, 1'b0);
        check("load_wait2", nop_e);
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("load_resume", set_e);

        cyc(9'b000011_000, 1'b1, 1'b0, 1'b0);
        check("beqz_issue", pk(0, 2'b10, 2'b10, 4'b0011, 0, 0, 0, 0, 1, 1, 0));
        cyc(9'b1_0000_0101, 1'b1, 1'b1, 1'b0);
        check("beqz_taken", pk(1, 2'b11, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("beqz_flush", nop_e);
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("beqz_target", set_e);

        cyc(9'b000011_000, 1'b1, 1'b1, 1'b0);
        check("beqz2_issue", pk(0, 2'b10, 2'b10, 4'b0011, 0, 0, 0, 0, 1, 1, 0));
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b1);
        check("beqz_not_taken", nop_e);
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("beqz_fallthrough", set_e);

        cyc(9'h000, 1'b1, 1'b0, 1'b0);
        check("halt_issue", pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 1, 1, 1, 1, 0));
        for (int i = 0; i < 10; i++) begin
            cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
            check("halt_held", pk(0, 2'b11, 2'b00, 4'd0, 0, 0, 0, 1, 1, 0, 0));
        end
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b1);
        check("halt_start", nop_e);
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("halt_resume", set_e);

        cyc(9'b000010_000, 1'b1, 1'b0, 1'b0);
        check("load_before_reset", pk(0, 2'b01, 2'b10, 4'b0010, 1, 0, 0, 0, 1, 1, 0));
        #3 Reset = 1'b0;
        #1 check("async_reset_mid_stall", nop_e);
        #2 Reset = 1'b1;
        cyc(9'b1_0000_0101, 1'b1, 1'b0, 1'b0);
        check("after_reset_run", set_e);

        for (int i = 0; i < 600; i++) begin
            logic [8:0] ins;
            logic v, z, s;
            logic [15:0] e;
            int r;
            r = $urandom_range(0, 15);
            ins = 9'($urandom);
            if (r < 2) ins[8:3] = 6'd2;
            else if (r < 4) ins[8:3] = 6'd3;
            else if (r == 4) ins[8:3] = 6'd0;
            v = ($urandom_range(0, 3) != 0);
            z = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0);
            model_step(ins, v, z, s, e);
            cyc(ins, v, z, s);
            check("random", e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
